// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Stores always go to backing memory; a store updates the line only when it already hits.
module dcache_wt #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dcache_addr,
   input  logic        dcache_wreq,
   input  logic        dcache_rreq,
   input  logic [31:0] dcache_wdata,
   input  logic [3:0]  dcache_byte_enable,
   output logic        dcache_wvalid,
   output logic [31:0] dcache_rdata,
   output logic        dcache_rvalid,
   output logic [31:0] mem_addr,
   output logic        mem_rreq,
   output logic        mem_wreq,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int LINES = 1 << INDEX_BITS;
   typedef enum logic [1:0] {IDLE, RMISS, WRITE, RESP} state_t;
   state_t state, state_n;
   logic [31:0] data [LINES];
   logic [TAG_BITS-1:0] tags [LINES];
   logic [LINES-1:0] valid;
   logic [1:0] off, off_r;
   logic [3:0] be_r;
   logic is_wr, hit, hit_r;
   logic [INDEX_BITS-1:0] idx, idx_r;
   logic [TAG_BITS-1:0] tag, tag_r;
   assign off = dcache_addr[1:0];
   assign idx = dcache_addr[INDEX_BITS+1:2];
   assign tag = dcache_addr[31:INDEX_BITS+2];
   // mem_addr doubles as the latched request address
   assign idx_r = mem_addr[INDEX_BITS+1:2];
   assign tag_r = mem_addr[31:INDEX_BITS+2];
   assign hit = valid[idx] && tags[idx] == tag;
   assign hit_r = valid[idx_r] && tags[idx_r] == tag_r;
   function automatic logic [31:0] align(input logic [31:0] w, input logic [1:0] o, input logic [3:0] b);
      return (w >> {o, 3'b000}) & {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
   endfunction
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state == IDLE ? (dcache_wreq ? WRITE : dcache_rreq ? (hit ? RESP : RMISS) : IDLE)
              : state == RESP ? IDLE
              : mem_ack ? RESP : state;
   end
   always_comb begin
      mem_rreq = state == RMISS;
      mem_wreq = state == WRITE;
      dcache_wvalid = state == RESP && is_wr;
      dcache_rvalid = state == RESP && !is_wr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         dcache_rdata <= '0;
         off_r <= '0;
         be_r <= '0;
         is_wr <= 1'b0;
      end else if (state == IDLE && (dcache_wreq || dcache_rreq)) begin
         mem_addr <= {dcache_addr[31:2], 2'b00};
         mem_wdata <= dcache_wdata << {off, 3'b000};
         mem_wstrb <= 4'(dcache_byte_enable << off);
         off_r <= off;
         be_r <= dcache_byte_enable;
         is_wr <= dcache_wreq;
         if (!dcache_wreq && hit) dcache_rdata <= align(data[idx], off, dcache_byte_enable);
      end else if (state == RMISS && mem_ack) begin
         valid[idx_r] <= 1'b1;
         dcache_rdata <= align(mem_rdata, off_r, be_r);
      end
   end
   always_ff @(posedge clk) begin
      if (state == RMISS && mem_ack) begin
         data[idx_r] <= mem_rdata;
         tags[idx_r] <= tag_r;
      end else if (state == WRITE && mem_ack && hit_r) begin
         for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) data[idx_r][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed checks of dcache_wt against hand-computed values.
// A negedge-driven responder models backing memory with a configurable ack latency.
module tb_dcache_wt;
   logic        clk = 0, rst = 1;
   logic [31:0] dcache_addr = 0, dcache_wdata = 0, dcache_rdata, mem_addr, mem_wdata, mem_rdata = 0;
   logic        dcache_wreq = 0, dcache_rreq = 0, dcache_wvalid, dcache_rvalid;
   logic [3:0]  dcache_byte_enable = 0, mem_wstrb;
   logic        mem_rreq, mem_wreq, mem_ack = 0;
   int total = 0, bad = 0;
   int lat = 3, cnt = 0, rq_cnt = 0, wq_cnt = 0, cyc;
   logic [31:0] rd_val = 0, ack_addr = 0, ack_wdata = 0, rdo;
   logic [3:0]  ack_strb = 0;
   logic        got_r, got_w;

   dcache_wt #(.INDEX_BITS(6)) dut (
      .clk(clk), .rst(rst), .dcache_addr(dcache_addr), .dcache_wreq(dcache_wreq),
      .dcache_rreq(dcache_rreq), .dcache_wdata(dcache_wdata), .dcache_byte_enable(dcache_byte_enable),
      .dcache_wvalid(dcache_wvalid), .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid),
      .mem_addr(mem_addr), .mem_rreq(mem_rreq), .mem_wreq(mem_wreq), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_ack) mem_ack = 0;
      else if (mem_rreq || mem_wreq) begin
         cnt++;
         if (cnt >= lat) begin
            mem_ack = 1;
            mem_rdata = rd_val;
            ack_addr = mem_addr;
            ack_wdata = mem_wdata;
            ack_strb = mem_wstrb;
            if (mem_rreq) rq_cnt++;
            else wq_cnt++;
            cnt = 0;
         end
      end else cnt = 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      @(negedge clk);
      dcache_addr = a; dcache_wreq = wr; dcache_rreq = rd; dcache_wdata = wd; dcache_byte_enable = be;
      cyc = 0; got_r = 0; got_w = 0;
      while (!(got_r || got_w) && cyc < 50) begin
         @(negedge clk);
         cyc++;
         got_r = dcache_rvalid;
         got_w = dcache_wvalid;
      end
      rdo = dcache_rdata;
      dcache_wreq = 0; dcache_rreq = 0;
      if (!(got_r || got_w)) chk("timeout", 32'(cyc), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_rvalid", 32'(dcache_rvalid), 0);
      chk("rst_wvalid", 32'(dcache_wvalid), 0);
      chk("rst_rdata", dcache_rdata, 0);
      chk("rst_mreq", {30'd0, mem_rreq, mem_wreq}, 0);
      chk("rst_maddr", mem_addr, 0);
      rst = 0;
      rd_val = 32'hDEADBEEF;
      op(0, 1, 32'h100, 0, 4'hF);
      chk("cold_rdata", rdo, 32'hDEADBEEF);
      chk("cold_rvalid", 32'(got_r), 1);
      chk("cold_lat", 32'(cyc), 4);
      chk("cold_rq", 32'(rq_cnt), 1);
      chk("cold_addr", ack_addr, 32'h100);
      @(negedge clk);
      chk("pulse_once", 32'(dcache_rvalid), 0);
      op(0, 1, 32'h100, 0, 4'hF);
      chk("hit_rdata", rdo, 32'hDEADBEEF);
      chk("hit_lat", 32'(cyc), 1);
      chk("hit_norq", 32'(rq_cnt), 1);
      op(0, 1, 32'h102, 0, 4'h1);
      chk("lb_102", rdo, 32'h000000AD);
      op(0, 1, 32'h102, 0, 4'h3);
      chk("lh_102", rdo, 32'h0000DEAD);
      op(1, 0, 32'h101, 32'h55, 4'h1);
      chk("sb_wvalid", 32'(got_w), 1);
      chk("sb_strb", 32'(ack_strb), 32'h2);
      chk("sb_wdata", ack_wdata, 32'h00005500);
      chk("sb_addr", ack_addr, 32'h100);
      chk("sb_wq", 32'(wq_cnt), 1);
      op(0, 1, 32'h100, 0, 4'hF);
      chk("sb_merge", rdo, 32'hDEAD55EF);
      chk("sb_merge_lat", 32'(cyc), 1);
      op(1, 0, 32'h200, 32'h12345678, 4'hF);
      chk("sw_miss_wq", 32'(wq_cnt), 2);
      chk("sw_miss_addr", ack_addr, 32'h200);
      rd_val = 32'h12345678;
      op(0, 1, 32'h200, 0, 4'hF);
      chk("noalloc_lat", 32'(cyc), 4);
      chk("noalloc_rq", 32'(rq_cnt), 2);
      chk("noalloc_rdata", rdo, 32'h12345678);
      rd_val = 32'hCAFEF00D;
      op(0, 1, 32'h100, 0, 4'hF);
      chk("alias_lat", 32'(cyc), 4);
      chk("alias_rdata", rdo, 32'hCAFEF00D);
      op(1, 1, 32'h104, 32'hA5A5A5A5, 4'hF);
      chk("prio_w", {30'd0, got_w, got_r}, 32'h2);
      chk("prio_wq", 32'(wq_cnt), 3);
      op(1, 0, 32'h103, 32'h0000BEEF, 4'h3);
      chk("mis_strb", 32'(ack_strb), 32'h8);
      chk("mis_wdata", ack_wdata, 32'hEF000000);
      op(1, 0, 32'h100, 32'hFFFFFFFF, 4'h0);
      chk("zero_strb", 32'(ack_strb), 0);
      chk("zero_wq", 32'(wq_cnt), 5);
      op(0, 1, 32'h100, 0, 4'hF);
      chk("mis_merge", rdo, 32'hEFFEF00D);
      chk("mis_merge_lat", 32'(cyc), 1);
      lat = 20;
      @(negedge clk);
      dcache_addr = 32'h140; dcache_rreq = 1; dcache_byte_enable = 4'hF;
      repeat (3) @(negedge clk);
      chk("mid_rreq", 32'(mem_rreq), 1);
      #1 rst = 1;
      #1 chk("rst_async_rreq", 32'(mem_rreq), 0);
      chk("rst_async_rvalid", 32'(dcache_rvalid), 0);
      dcache_rreq = 0;
      @(negedge clk);
      rst = 0;
      lat = 3;
      rd_val = 32'h11112222;
      op(0, 1, 32'h100, 0, 4'hF);
      chk("post_rst_lat", 32'(cyc), 4);
      chk("post_rst_rdata", rdo, 32'h11112222);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache directly downstream of the memory stage.
- Serves that stage's load/store requests (addr, wreq/rreq, wdata, byte_enable) and returns wvalid/rvalid pulses plus right-aligned read data.
- Misses and all stores go to a backing data memory over a simple req/ack handshake.
- One-word (32-bit) lines.

Parameters:
- INDEX_BITS, 6: number of index bits; the cache has 2^INDEX_BITS lines. Tag width = 30 - INDEX_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- dcache_addr  input  32  byte address from the memory stage.
- dcache_wreq  input  1  store request; held until wvalid.
- dcache_rreq  input  1  load request; held until rvalid.
- dcache_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dcache_byte_enable  input  4  right-aligned byte mask: 0001, 0011 or 1111.
- dcache_wvalid  output  1  one-cycle store-complete pulse.
- dcache_rdata  output  32  load data, right-aligned, upper bytes zero.
- dcache_rvalid  output  1  one-cycle load-complete pulse.
- mem_addr  output  32  word-aligned backing address {dcache_addr[31:2],2'b00}.
- mem_rreq  output  1  backing read request.
- mem_wreq  output  1  backing write request.
- mem_wdata  output  32  lane-aligned write data.
- mem_wstrb  output  4  lane-aligned byte strobes.
- mem_rdata  input  32  backing read data; valid when mem_ack=1 during a read.
- mem_ack  input  1  backing-side completion; single-cycle pulse.

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; all line valid bits=0; dcache_wvalid=0, dcache_rvalid=0, dcache_rdata=0, mem_rreq=0, mem_wreq=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- Addressing: off = addr[1:0], index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Lane alignment:
  - strobe = (byte_enable << off) truncated to 4 bits; wdata_al = wdata << (8*off).
  - Misaligned overflow bits are dropped, never wrapped.
- FSM states: IDLE, RMISS, WRITE, RESP.
- IDLE, request sampling:
  - wreq has priority over rreq when both are high.
  - wreq -> latch request fields and go to WRITE.
  - rreq and hit (valid[index] and tag match) -> go to RESP with rvalid=1. dcache_rdata = (line >> 8*off) masked by byte_enable; unmasked bytes are 0.
  - rreq and miss -> latch fields and go to RMISS.
  - No request -> stay in IDLE.
- RMISS:
  - mem_rreq=1 and mem_addr held stable until mem_ack.
  - On ack: write mem_rdata into the line, set valid and tag, drive dcache_rdata from mem_rdata (same shift/mask), go to RESP with rvalid=1.
- WRITE:
  - mem_wreq=1; mem_wdata/mem_wstrb/mem_addr held until mem_ack.
  - On ack: if the line hits, merge strobed bytes into it (miss leaves the cache unchanged).
  - Then go to RESP with wvalid=1.
- RESP:
  - The valid pulse is high for exactly this one cycle; next state is IDLE unconditionally.
  - Requests are not re-sampled in RESP, so a held request is never served twice.
- Latency:
  - Read hit: request sampled at edge N, rvalid high in cycle N+1.
  - Miss or store: rvalid/wvalid in the cycle after mem_ack.
- Hold behaviour: dcache_rdata holds its last value outside RESP. mem_rreq/mem_wreq deassert in the cycle after the ack.
- Ack outside RMISS/WRITE is ignored.
- Write with strobe=0000: still issues the backing write with mem_wstrb=0, then wvalid.
- Reset mid-operation: state returns to IDLE immediately and mem_rreq/mem_wreq drop asynchronously. No partial line fill; all valid bits cleared.

Test Plan:
- Cold load: rreq, addr=0x100, mem returns 0xDEADBEEF after 3 cycles -> one mem_rreq to 0x100, rvalid pulses once, dcache_rdata=0xDEADBEEF. Repeat same load -> rvalid one cycle after request, no mem_rreq.
- Byte load: line 0x100 holds 0xDEADBEEF; rreq addr=0x102, be=0001 -> dcache_rdata=0x000000AD. addr=0x102, be=0011 -> 0x0000DEAD.
- Store hit: sb 0x55 to addr=0x101 -> mem_wstrb=0010, mem_wdata=0x00005500, mem_addr=0x100. After ack, wvalid=1; a subsequent lw 0x100 hits with 0xDEAD55EF.
- Store miss: sw 0x12345678 to 0x200 (line invalid) -> backing write, wvalid. Next lw 0x200 misses and issues mem_rreq (no allocate).
- Conflict and priority: wreq and rreq both high -> store path taken. Index aliasing: addr 0x100 then 0x100+(4<<INDEX_BITS) -> second access misses and replaces the line.
- Reset mid-miss: assert rst while mem_rreq=1 -> mem_rreq=0 immediately, no rvalid. After release, lw 0x100 misses again.
